// File: rtl/sn_encoder.sv
// rtl/sn_encoder.sv - bipolar stochastic bitstream encoder; optional feature macro SNG_RESEED_EN
module sn_encoder #(
    parameter int         LANES     = 4,
    parameter int         WIDTH     = 4,
    parameter logic [7:0] LFSR_SEED = 8'h5A
) (
    input  logic                 i_clk_sng,
    input  logic                 i_rst_sng,
    input  logic                 i_start_sng,
    input  logic [WIDTH-1:0]     i_x_sng [LANES],
    input  logic [7:0]           i_len_sng,
    input  logic                 i_hold_sng,
    output logic                 o_valid_sng,
    output logic [LANES-1:0]     o_sn_bit_sng,
    output logic                 o_busy_sng,
    output logic                 o_done_sng
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0]       SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    // Flipping the sign bit turns two's complement into offset binary.
    localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                        state_q, state_d;
    logic [7:0]                    cnt_q, cnt_d;
    logic [7:0]                    len_q, len_d;
    logic [LANES-1:0][WIDTH-1:0]   u_q, u_d;
    logic [7:0]                    lfsr_q, lfsr_d;
    logic                          valid_d;
    logic [LANES-1:0]              bit_d;
    logic                          busy_d;
    logic                          done_d;

    logic                          emit;
    logic [LANES-1:0][WIDTH-1:0]   src_u;
    logic [7:0]                    src_lfsr;

    function automatic logic [7:0] lfsr_next(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    endfunction

    function automatic logic [WIDTH-1:0] lane_window(input logic [7:0] r, input int k);
        logic [7:0] s;
        s = r >> k;
        return s[WIDTH-1:0];
    endfunction

    // State, latched operands, LFSR and registered outputs; reset clears outputs immediately.
    always_ff @(posedge i_clk_sng or negedge i_rst_sng) begin
        if (!i_rst_sng) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            len_q        <= 8'd0;
            u_q          <= '0;
            lfsr_q       <= SEED_EFF;
            o_valid_sng  <= 1'b0;
            o_sn_bit_sng <= '0;
            o_busy_sng   <= 1'b0;
            o_done_sng   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            u_q          <= u_d;
            lfsr_q       <= lfsr_d;
            o_valid_sng  <= valid_d;
            o_sn_bit_sng <= bit_d;
            o_busy_sng   <= busy_d;
            o_done_sng   <= done_d;
        end
    end

    // Next state and next outputs; the first bit is produced on the accepting edge
    // straight from the sampled inputs so it appears in the cycle after accept.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        u_d      = u_q;
        lfsr_d   = lfsr_q;
        valid_d  = 1'b0;
        bit_d    = o_sn_bit_sng;
        done_d   = 1'b0;
        emit     = 1'b0;
        src_u    = u_q;
        src_lfsr = lfsr_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start_sng) begin
                    len_d = i_len_sng;
                    cnt_d = 8'd0;
                    for (int k = 0; k < LANES; k++) begin
                        u_d[k] = i_x_sng[k] ^ SIGN_BIT;
                    end
`ifdef SNG_RESEED_EN
                    src_lfsr = SEED_EFF;
                    lfsr_d   = SEED_EFF;
`else
                    src_lfsr = lfsr_q;
`endif
                    if (i_len_sng == 8'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        emit    = 1'b1;
                        src_u   = u_d;
                    end
                end
            end
            ST_RUN: begin
                if (!i_hold_sng) begin
                    if (cnt_q == len_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        emit = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit) begin
            valid_d = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                bit_d[k] = (src_u[k] > lane_window(src_lfsr, k));
            end
            lfsr_d = lfsr_next(src_lfsr);
            cnt_d  = cnt_d + 8'd1;
        end

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_sn_encoder.sv
// tb/tb_sn_encoder.sv - directed self-checking bench for sn_encoder
module tb_sn_encoder;

    localparam logic [7:0] SEED = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] x_in [4];
    logic [7:0] len_in;
    logic       hold;
    logic       valid;
    logic [3:0] sn_bit;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_lfsr;
    logic [3:0] obs_q[$];
    logic [3:0] exp_q[$];
    int vcnt, done_cyc, done_cnt, busy_low, hold_cyc, hold_err;
    int ones[4];

    sn_encoder #(
        .LANES    (4),
        .WIDTH    (4),
        .LFSR_SEED(SEED)
    ) dut (
        .i_clk_sng   (clk),
        .i_rst_sng   (rst_n),
        .i_start_sng (start),
        .i_x_sng     (x_in),
        .i_len_sng   (len_in),
        .i_hold_sng  (hold),
        .o_valid_sng (valid),
        .o_sn_bit_sng(sn_bit),
        .o_busy_sng  (busy),
        .o_done_sng  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    endfunction

    task automatic model_stream(input logic [3:0] xv [4], input int len);
        logic [3:0] b;
        logic [3:0] u;
        logic [7:0] s;
`ifdef SNG_RESEED_EN
        m_lfsr = SEED;
`endif
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < 4; k++) begin
                u    = xv[k] ^ 4'h8;
                s    = m_lfsr >> k;
                b[k] = (u > s[3:0]);
            end
            exp_q.push_back(b);
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    function automatic int stream_diff();
        int d;
        int n;
        d = 0;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        if (obs_q.size() != exp_q.size()) d += 1000;
        for (int i = 0; i < n; i++) begin
            if (obs_q[i] !== exp_q[i]) d++;
        end
        return d;
    endfunction

    task automatic run_stream(input logic [3:0] xv [4], input int len, input int hold_after,
                              input int hold_n, input int spurious_at);
        int         hold_left;
        bit         hold_started;
        logic [3:0] last;
        obs_q.delete();
        vcnt = 0; done_cyc = -1; done_cnt = 0; busy_low = -1; hold_cyc = 0; hold_err = 0;
        for (int k = 0; k < 4; k++) ones[k] = 0;
        hold_left = 0; hold_started = 0; last = '0;
        x_in = xv; len_in = len[7:0]; hold = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (!busy) begin
                busy_low = c;
                break;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (valid) begin
                obs_q.push_back(sn_bit);
                vcnt++;
                for (int k = 0; k < 4; k++) ones[k] += int'(sn_bit[k]);
                last = sn_bit;
            end else if (!done && vcnt > 0) begin
                hold_cyc++;
                if (sn_bit !== last) hold_err++;
            end
            start = 1'b0;
            if (c == spurious_at) begin
                start = 1'b1;
                for (int k = 0; k < 4; k++) x_in[k] = ~xv[k];
                len_in = 8'd3;
            end
            if (hold_n > 0 && !hold_started && vcnt == hold_after) begin
                hold_started = 1;
                hold_left    = hold_n;
            end
            if (hold_left > 0) begin
                hold = 1'b1;
                hold_left--;
            end else begin
                hold = 1'b0;
            end
            @(posedge clk); #1;
        end
        hold = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; len_in = 8'd0;
        for (int k = 0; k < 4; k++) x_in[k] = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({valid, busy, done, sn_bit} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000", {valid, busy, done, sn_bit});
        end
        rst_n = 1'b1;
        m_lfsr = SEED;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_all_neg8();
        logic [3:0] xv [4];
        xv = '{4'h8, 4'h8, 4'h8, 4'h8};
        exp_q.delete();
        model_stream(xv, 16);
        run_stream(xv, 16, 0, 0, -1);
        checks++;
        if (vcnt !== 16) begin errors++; $display("FAIL neg8_valid_count: got %0d expected 16", vcnt); end
        checks++;
        if (ones[0] + ones[1] + ones[2] + ones[3] !== 0) begin
            errors++; $display("FAIL neg8_ones: got %0d expected 0", ones[0] + ones[1] + ones[2] + ones[3]);
        end
        checks++;
        if (done_cyc !== 17) begin errors++; $display("FAIL neg8_done_cycle: got %0d expected 17", done_cyc); end
        checks++;
        if (busy_low !== 18) begin errors++; $display("FAIL neg8_busy_low: got %0d expected 18", busy_low); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL neg8_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_full_period();
        logic [3:0] xv [4];
        int         exp_ones [4];
        xv = '{4'h7, 4'h0, 4'hF, 4'h8};
        exp_ones = '{239, 127, 111, 0};
        exp_q.delete();
        model_stream(xv, 255);
        run_stream(xv, 255, 0, 0, -1);
        checks++;
        if (vcnt !== 255) begin errors++; $display("FAIL period_valid_count: got %0d expected 255", vcnt); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ones[k] !== exp_ones[k]) begin
                errors++; $display("FAIL period_ones_lane%0d: got %0d expected %0d", k, ones[k], exp_ones[k]);
            end
        end
        checks++;
        if (stream_diff() !== 0) begin errors++; $display("FAIL period_stream: got %0d diffs expected 0", stream_diff()); end
        checks++;
        if (done_cyc !== 256) begin errors++; $display("FAIL period_done_cycle: got %0d expected 256", done_cyc); end
    endtask

    task automatic test_hold();
        logic [3:0] xv [4];
        xv = '{4'h3, 4'hC, 4'h5, 4'h1};
        exp_q.delete();
        model_stream(xv, 10);
        run_stream(xv, 10, 4, 3, -1);
        checks++;
        if (vcnt !== 10) begin errors++; $display("FAIL hold_valid_count: got %0d expected 10", vcnt); end
        checks++;
        if (hold_cyc !== 3) begin errors++; $display("FAIL hold_gap_cycles: got %0d expected 3", hold_cyc); end
        checks++;
        if (hold_err !== 0) begin errors++; $display("FAIL hold_bits_retained: got %0d changes expected 0", hold_err); end
        checks++;
        if (done_cyc !== 14) begin errors++; $display("FAIL hold_done_cycle: got %0d expected 14", done_cyc); end
        checks++;
        if (stream_diff() !== 0) begin errors++; $display("FAIL hold_stream: got %0d diffs expected 0", stream_diff()); end
    endtask

    task automatic test_start_in_run();
        logic [3:0] xv [4];
        xv = '{4'h1, 4'h2, 4'hD, 4'h4};
        exp_q.delete();
        model_stream(xv, 8);
        run_stream(xv, 8, 0, 0, 3);
        checks++;
        if (vcnt !== 8) begin errors++; $display("FAIL spurious_valid_count: got %0d expected 8", vcnt); end
        checks++;
        if (done_cyc !== 9) begin errors++; $display("FAIL spurious_done_cycle: got %0d expected 9", done_cyc); end
        checks++;
        if (stream_diff() !== 0) begin errors++; $display("FAIL spurious_stream: got %0d diffs expected 0", stream_diff()); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL spurious_stays_idle: got %b expected 0", busy); end
    endtask

    task automatic test_len_zero();
        logic [3:0] xv [4];
        xv = '{4'h7, 4'h7, 4'h7, 4'h7};
        exp_q.delete();
        model_stream(xv, 0);
        run_stream(xv, 0, 0, 0, -1);
        checks++;
        if (vcnt !== 0) begin errors++; $display("FAIL len0_valid_count: got %0d expected 0", vcnt); end
        checks++;
        if (done_cyc !== 1) begin errors++; $display("FAIL len0_done_cycle: got %0d expected 1", done_cyc); end
        checks++;
        if (busy_low !== 2) begin errors++; $display("FAIL len0_busy_low: got %0d expected 2", busy_low); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] xv [4];
        logic [3:0] first_q[$];
        xv = '{4'h6, 4'hA, 4'h0, 4'h3};
        exp_q.delete();
        model_stream(xv, 8);
        run_stream(xv, 8, 0, 0, -1);
        first_q = obs_q;
        checks++;
        if (stream_diff() !== 0) begin errors++; $display("FAIL b2b_first_stream: got %0d diffs expected 0", stream_diff()); end
        exp_q.delete();
        model_stream(xv, 8);
        run_stream(xv, 8, 0, 0, -1);
        checks++;
        if (vcnt !== 8) begin errors++; $display("FAIL b2b_second_count: got %0d expected 8", vcnt); end
        checks++;
        if (stream_diff() !== 0) begin errors++; $display("FAIL b2b_second_stream: got %0d diffs expected 0", stream_diff()); end
`ifdef SNG_RESEED_EN
        checks++;
        if (obs_q != first_q) begin errors++; $display("FAIL b2b_reseed_identical: got %p expected %p", obs_q, first_q); end
`endif
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] xv [4];
        xv = '{4'h7, 4'h0, 4'hF, 4'h8};
        x_in = xv; len_in = 8'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid, busy, done, sn_bit} !== 7'b0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got %b expected 0000000", {valid, busy, done, sn_bit});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_lfsr = SEED;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrun_idle_after: got %b expected 0", busy); end
        exp_q.delete();
        model_stream(xv, 12);
        run_stream(xv, 12, 0, 0, -1);
        checks++;
        if (obs_q.size() == 0 || obs_q[0] !== 4'b0101) begin
            errors++;
            $display("FAIL midrun_first_bit: got %b expected 0101", (obs_q.size() == 0) ? 4'bxxxx : obs_q[0]);
        end
        checks++;
        if (stream_diff() !== 0) begin errors++; $display("FAIL midrun_stream: got %0d diffs expected 0", stream_diff()); end
    endtask

    initial begin
        test_reset();
        test_all_neg8();
        test_full_period();
        test_hold();
        test_start_in_run();
        test_len_zero();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/sn_encoder.md
# sn_encoder

Binary-to-stochastic encoder producing bipolar stochastic bitstreams from signed 4-bit values. Sits upstream of the up/down-counter accumulators in the MVM path. Each lane compares its offset-binary value against a shared LFSR window to emit one bit per cycle for a programmed stream length. A start/busy/done handshake and a hold input frame the output.

## Interface
- LANES, 4, number of parallel bitstream lanes; legal range 1..5.
- WIDTH, 4, bit width of each signed input value.
- LFSR_SEED, 8'h5A, LFSR load value; a value of 0 is replaced by 8'h01.
- i_clk_sng  input  1  clock; all state updates on the rising edge.
- i_rst_sng  input  1  reset; asynchronous, active-low.
- i_start_sng  input  1  request a new stream; accepted only in IDLE.
- i_x_sng  input  [WIDTH-1:0] x [LANES]  signed two's-complement lane values; sampled on accept.
- i_len_sng  input  8  stream length in valid bits; sampled on accept.
- i_hold_sng  input  1  stall; freezes generation while high in RUN.
- o_valid_sng  output  1  o_sn_bit_sng carries a new bit this cycle.
- o_sn_bit_sng  output  1 x [LANES]  stochastic bit per lane.
- o_busy_sng  output  1  high in RUN and DONE.
- o_done_sng  output  1  one-cycle pulse in DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on i_start_sng with len≠0.
  - IDLE→DONE on i_start_sng with len=0.
  - RUN→DONE after the len-th valid bit.
  - DONE→IDLE unconditionally.
- On accept:
  - latch each x_k as offset binary u_k = x_k ^ (1<<(WIDTH-1)), giving 0..15.
  - latch len and clear the bit counter.
- LFSR: 8-bit Fibonacci; shift left; new lsb = r[7]^r[5]^r[4]^r[3]; period 255.
  - Advances only on valid cycles (RUN and not hold).
- Lane k random window r_k = lfsr[k+WIDTH-1:k].
- Lane k bit = (u_k > r_k), unsigned compare, using the pre-advance LFSR state.
- x=-8 always yields 0; x=7 yields 0 only when r_k=15.
- Hold in RUN:
  - o_valid_sng=0; o_sn_bit_sng retains its last value.
  - LFSR and bit counter frozen.
- i_start_sng in RUN or DONE is ignored. Latched x and len are unaffected by input changes after accept.
- Reset (any time, including mid-stream):
  - state=IDLE, counter=0, LFSR=LFSR_SEED.
  - all outputs 0 immediately (asynchronous).

## Timing
- Start accepted at edge T: o_busy_sng=1 and first valid bit during cycle T+1.
- With no hold, valid bits occupy cycles T+1..T+len.
- o_done_sng is high in cycle T+len+1; o_busy_sng falls at T+len+2, when the FSM is back in IDLE.
- Each hold cycle in RUN delays the remaining bits and done by one cycle.
- len=0: DONE in T+1 with no valid bits, IDLE at T+2.
- Earliest next start is accepted in IDLE, i.e. at edge T+len+2.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SNG_RESEED_EN defined: the LFSR reloads LFSR_SEED on every accepted start, so identical inputs give identical streams per run.
- SNG_RESEED_EN undefined: the LFSR loads the seed only at reset and continues its sequence across runs.

## Test plan
- Reset: assert i_rst_sng low mid-RUN → all outputs 0 at once; after release, the FSM is in IDLE and the next run starts from LFSR_SEED.
- All lanes x=-8, len=16, no hold:
  - exactly 16 valid cycles, every bit 0.
  - o_done_sng in cycle T+17; o_busy_sng low at T+18.
- len=255, lanes x={7,0,-1,-8}: per-lane ones count exactly {239,127,111,0}, because each 4-bit window value 1..15 occurs 16 times per period and 0 occurs 15 times.
- len=10 with i_hold_sng high for 3 cycles after the 4th bit:
  - o_valid_sng low during the hold, bits held.
  - total valid count 10; done at T+14.
- Start corner cases:
  - start pulsed during RUN → ignored, stream unchanged.
  - len=0 → done pulse at T+1, zero valid cycles.
- Two back-to-back len=8 runs with identical x:
  - with SNG_RESEED_EN, the streams are identical.
  - without it, the second stream continues the LFSR sequence from state 8.
